// File: rtl/carga_serial_izq_der_pkg.sv
// Shared definitions for the serial left/right word loader and its comparator.
// Holds the FSM encoding, the default widths and the bit-counter width helper.
package carga_serial_izq_der_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } estado_e;

    localparam int N_PALABRA = 3;
    localparam int CW_CUENTA = 8;

    // Bit-counter width: $clog2(n), never narrower than one bit.
    function automatic int ancho_cnt(input int n);
        if (n > 2) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/carga_serial_izq_der_if.sv
// Handshake and data bundle between the serial source, the loader and the comparator.
// The master drives the serial lanes and acceptance; the slave presents the words.
interface carga_serial_izq_der_if
    import carga_serial_izq_der_pkg::*;
#(
    parameter int N  = N_PALABRA,
    parameter int CW = CW_CUENTA
) ();

    logic          inicio;
    logic          bit_valido;
    logic          bit_a;
    logic          bit_b;
    logic          acept;
    logic [N-1:0]  palabraA;
    logic [N-1:0]  palabraB;
    logic          palabra_valida;
    logic          ocupado;
    logic          error_trama;
    logic [CW-1:0] cuenta_tramas;

    modport master (
        output inicio, bit_valido, bit_a, bit_b, acept,
        input  palabraA, palabraB, palabra_valida, ocupado, error_trama, cuenta_tramas
    );

    modport slave (
        input  inicio, bit_valido, bit_a, bit_b, acept,
        output palabraA, palabraB, palabra_valida, ocupado, error_trama, cuenta_tramas
    );

endinterface

// File: rtl/carga_serial_izq_der_registro_serie.sv
// One N-bit MSB-first shift register with synchronous clear (priority) and enable.
// desp_o exposes the value the register takes on an enabled shift this cycle.
module registro_serie_izq_der #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         bit_i,
    output logic [N-1:0] desp_o
);

    logic [N-1:0] reg_q;
    logic [N-1:0] reg_d;
    logic [N-1:0] desp_s;

    assign desp_s = (reg_q << 1) | {{(N-1){1'b0}}, bit_i};
    assign desp_o = desp_s;

    // Next-state selection: clear beats shift.
    always_comb begin
        reg_d = reg_q;
        if (clr_i) begin
            reg_d = {N{1'b0}};
        end else if (en_i) begin
            reg_d = desp_s;
        end else begin
            reg_d = reg_q;
        end
    end

    // Shift register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q <= {N{1'b0}};
        end else begin
            reg_q <= reg_d;
        end
    end

endmodule

// File: rtl/carga_serial_izq_der.sv
// Assembles two MSB-first serial lanes into parallel words for the left/right comparator,
// holding each completed frame until accepted, flagging aborted frames and counting deliveries.
module carga_serial_izq_der
    import carga_serial_izq_der_pkg::*;
#(
    parameter int N  = N_PALABRA,
    parameter int CW = CW_CUENTA
) (
    input  logic                  clk,
    input  logic                  rst_n,
    carga_serial_izq_der_if.slave bus
);

    localparam int CNTW = ancho_cnt(N);
    localparam logic [CNTW-1:0] CNT_ULTIMO = CNTW'(N - 1);

    estado_e         estado_q, estado_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    pal_a_q, pal_a_d;
    logic [N-1:0]    pal_b_q, pal_b_d;
    logic            valida_q, valida_d;
    logic            ocupado_q, ocupado_d;
    logic            error_q, error_d;
    logic [CW-1:0]   cuenta_q, cuenta_d;
    logic            clr_s;
    logic            en_s;
    logic [N-1:0]    desp_a_s;
    logic [N-1:0]    desp_b_s;

    registro_serie_izq_der #(.N(N)) u_lane_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr_s),
        .en_i   (en_s),
        .bit_i  (bus.bit_a),
        .desp_o (desp_a_s)
    );

    registro_serie_izq_der #(.N(N)) u_lane_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr_s),
        .en_i   (en_s),
        .bit_i  (bus.bit_b),
        .desp_o (desp_b_s)
    );

    // Frame FSM: next state, shift control and next values of every registered output.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        pal_a_d  = pal_a_q;
        pal_b_d  = pal_b_q;
        valida_d = valida_q;
        error_d  = 1'b0;
        cuenta_d = cuenta_q;
        clr_s    = 1'b0;
        en_s     = 1'b0;
        case (estado_q)
            IDLE: begin
                valida_d = 1'b0;
                if (bus.inicio) begin
                    estado_d = SHIFT;
                    clr_s    = 1'b1;
                    cnt_d    = {CNTW{1'b0}};
                end else begin
                    estado_d = IDLE;
                end
            end
            SHIFT: begin
                // A restart discards the partial frame even if a bit arrives with it.
                if (bus.inicio) begin
                    clr_s   = 1'b1;
                    cnt_d   = {CNTW{1'b0}};
                    error_d = 1'b1;
                end else if (bus.bit_valido) begin
                    en_s = 1'b1;
                    if (cnt_q == CNT_ULTIMO) begin
                        estado_d = HOLD;
                        cnt_d    = {CNTW{1'b0}};
                        pal_a_d  = desp_a_s;
                        pal_b_d  = desp_b_s;
                        valida_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end else begin
                    estado_d = SHIFT;
                end
            end
            HOLD: begin
                if (bus.acept) begin
                    cuenta_d = cuenta_q + CW'(1);
                    valida_d = 1'b0;
                    if (bus.inicio) begin
                        estado_d = SHIFT;
                        clr_s    = 1'b1;
                        cnt_d    = {CNTW{1'b0}};
                    end else begin
                        estado_d = IDLE;
                    end
                end else begin
                    estado_d = HOLD;
                end
            end
            default: begin
                estado_d = IDLE;
                cnt_d    = {CNTW{1'b0}};
                valida_d = 1'b0;
            end
        endcase
        ocupado_d = (estado_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= IDLE;
            cnt_q     <= {CNTW{1'b0}};
            pal_a_q   <= {N{1'b0}};
            pal_b_q   <= {N{1'b0}};
            valida_q  <= 1'b0;
            ocupado_q <= 1'b0;
            error_q   <= 1'b0;
            cuenta_q  <= {CW{1'b0}};
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            pal_a_q   <= pal_a_d;
            pal_b_q   <= pal_b_d;
            valida_q  <= valida_d;
            ocupado_q <= ocupado_d;
            error_q   <= error_d;
            cuenta_q  <= cuenta_d;
        end
    end

    assign bus.palabraA       = pal_a_q;
    assign bus.palabraB       = pal_b_q;
    assign bus.palabra_valida = valida_q;
    assign bus.ocupado        = ocupado_q;
    assign bus.error_trama    = error_q;
    assign bus.cuenta_tramas  = cuenta_q;

endmodule

// File: tb/tb_carga_serial_izq_der.sv
// Directed bench for carga_serial_izq_der: frames, backpressure, abort, back-to-back,
// gapped bits, asynchronous reset and counter wrap, each with hand-computed expectations.
module tb_carga_serial_izq_der;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    carga_serial_izq_der_if #(.N(3), .CW(8)) bus ();

    carga_serial_izq_der #(.N(3), .CW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.inicio     = 1'b0;
        bus.bit_valido = 1'b0;
        bus.bit_a      = 1'b0;
        bus.bit_b      = 1'b0;
        bus.acept      = 1'b0;
    endtask

    task automatic start_frame();
        bus.inicio = 1'b1;
        tick();
        bus.inicio = 1'b0;
    endtask

    task automatic send_bit(input logic a, input logic b);
        bus.bit_valido = 1'b1;
        bus.bit_a      = a;
        bus.bit_b      = b;
        tick();
        bus.bit_valido = 1'b0;
        bus.bit_a      = 1'b0;
        bus.bit_b      = 1'b0;
    endtask

    task automatic load_frame(input logic [2:0] a, input logic [2:0] b);
        start_frame();
        for (int i = 2; i >= 0; i--) begin
            send_bit(a[i], b[i]);
        end
    endtask

    task automatic accept();
        bus.acept = 1'b1;
        tick();
        bus.acept = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({bus.palabraA, bus.palabraB, bus.palabra_valida, bus.ocupado,
             bus.error_trama, bus.cuenta_tramas} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs got A=%b B=%b v=%b o=%b e=%b c=%0d required all zero",
                     bus.palabraA, bus.palabraB, bus.palabra_valida, bus.ocupado,
                     bus.error_trama, bus.cuenta_tramas);
        end
    endtask

    task automatic test_basic();
        start_frame();
        checks++;
        if (bus.ocupado !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %b required 1", bus.ocupado);
        end
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        checks++;
        if (bus.palabra_valida !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid got %b required 0", bus.palabra_valida);
        end
        send_bit(1'b1, 1'b1);
        checks++;
        if ({bus.palabra_valida, bus.palabraA, bus.palabraB} !== 7'b1_101_011) begin
            errors++;
            $display("FAIL basic_words got v=%b A=%b B=%b required v=1 A=101 B=011",
                     bus.palabra_valida, bus.palabraA, bus.palabraB);
        end
        accept();
        checks++;
        if ({bus.palabra_valida, bus.ocupado, bus.cuenta_tramas} !== 10'b0_0_00000001) begin
            errors++;
            $display("FAIL basic_accept got v=%b o=%b c=%0d required v=0 o=0 c=1",
                     bus.palabra_valida, bus.ocupado, bus.cuenta_tramas);
        end
    endtask

    task automatic test_backpressure();
        load_frame(3'b110, 3'b110);
        for (int i = 0; i < 5; i++) begin
            bus.bit_valido = (i % 2 == 0) ? 1'b1 : 1'b0;
            bus.bit_a      = 1'(i);
            bus.bit_b      = ~1'(i);
            tick();
            checks++;
            if ({bus.palabra_valida, bus.palabraA, bus.palabraB} !== 7'b1_110_110) begin
                errors++;
                $display("FAIL backpressure_hold[%0d] got v=%b A=%b B=%b required v=1 A=110 B=110",
                         i, bus.palabra_valida, bus.palabraA, bus.palabraB);
            end
        end
        idle_inputs();
        accept();
        checks++;
        if ({bus.palabra_valida, bus.ocupado, bus.cuenta_tramas} !== 10'b0_0_00000010) begin
            errors++;
            $display("FAIL backpressure_accept got v=%b o=%b c=%0d required v=0 o=0 c=2",
                     bus.palabra_valida, bus.ocupado, bus.cuenta_tramas);
        end
    endtask

    task automatic test_abort();
        start_frame();
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        bus.inicio     = 1'b1;
        bus.bit_valido = 1'b1;
        bus.bit_a      = 1'b1;
        bus.bit_b      = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if ({bus.error_trama, bus.ocupado, bus.palabraA, bus.palabraB} !== 8'b1_1_110_110) begin
            errors++;
            $display("FAIL abort_pulse got e=%b o=%b A=%b B=%b required e=1 o=1 A=110 B=110",
                     bus.error_trama, bus.ocupado, bus.palabraA, bus.palabraB);
        end
        tick();
        checks++;
        if (bus.error_trama !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse_width got %b required 0", bus.error_trama);
        end
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        checks++;
        if (bus.palabra_valida !== 1'b0) begin
            errors++;
            $display("FAIL abort_counter_cleared got v=%b required 0", bus.palabra_valida);
        end
        send_bit(1'b0, 1'b0);
        checks++;
        if ({bus.palabra_valida, bus.palabraA, bus.palabraB} !== 7'b1_010_010) begin
            errors++;
            $display("FAIL abort_words got v=%b A=%b B=%b required v=1 A=010 B=010",
                     bus.palabra_valida, bus.palabraA, bus.palabraB);
        end
        accept();
        checks++;
        if (bus.cuenta_tramas !== 8'd3) begin
            errors++;
            $display("FAIL abort_count got %0d required 3", bus.cuenta_tramas);
        end
    endtask

    task automatic test_back_to_back();
        load_frame(3'b101, 3'b010);
        bus.acept  = 1'b1;
        bus.inicio = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if ({bus.palabra_valida, bus.ocupado, bus.cuenta_tramas} !== 10'b0_1_00000100) begin
            errors++;
            $display("FAIL b2b_no_idle got v=%b o=%b c=%0d required v=0 o=1 c=4",
                     bus.palabra_valida, bus.ocupado, bus.cuenta_tramas);
        end
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1, 1'b0);
        end
        checks++;
        if ({bus.palabra_valida, bus.palabraA, bus.palabraB} !== 7'b1_111_000) begin
            errors++;
            $display("FAIL b2b_words got v=%b A=%b B=%b required v=1 A=111 B=000",
                     bus.palabra_valida, bus.palabraA, bus.palabraB);
        end
        accept();
        checks++;
        if ({bus.ocupado, bus.cuenta_tramas} !== 9'b0_00000101) begin
            errors++;
            $display("FAIL b2b_count got o=%b c=%0d required o=0 c=5",
                     bus.ocupado, bus.cuenta_tramas);
        end
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1, 1'b1);
            checks++;
            if ({bus.ocupado, bus.palabra_valida} !== 2'b00) begin
                errors++;
                $display("FAIL idle_noise[%0d] got o=%b v=%b required o=0 v=0",
                         i, bus.ocupado, bus.palabra_valida);
            end
        end
        start_frame();
        send_bit(1'b0, 1'b1);
        repeat (4) tick();
        send_bit(1'b1, 1'b0);
        repeat (4) tick();
        checks++;
        if ({bus.palabra_valida, bus.ocupado} !== 2'b01) begin
            errors++;
            $display("FAIL gaps_waiting got v=%b o=%b required v=0 o=1",
                     bus.palabra_valida, bus.ocupado);
        end
        send_bit(1'b1, 1'b0);
        checks++;
        if ({bus.palabra_valida, bus.palabraA, bus.palabraB} !== 7'b1_011_100) begin
            errors++;
            $display("FAIL gaps_words got v=%b A=%b B=%b required v=1 A=011 B=100",
                     bus.palabra_valida, bus.palabraA, bus.palabraB);
        end
        start_frame();
        checks++;
        if ({bus.error_trama, bus.palabra_valida, bus.palabraA, bus.palabraB} !== 8'b0_1_011_100) begin
            errors++;
            $display("FAIL hold_ignores_start got e=%b v=%b A=%b B=%b required e=0 v=1 A=011 B=100",
                     bus.error_trama, bus.palabra_valida, bus.palabraA, bus.palabraB);
        end
        accept();
        checks++;
        if (bus.cuenta_tramas !== 8'd6) begin
            errors++;
            $display("FAIL gaps_count got %0d required 6", bus.cuenta_tramas);
        end
    endtask

    task automatic test_async_reset();
        start_frame();
        send_bit(1'b1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.palabraA, bus.palabraB, bus.palabra_valida, bus.ocupado,
             bus.error_trama, bus.cuenta_tramas} !== 18'd0) begin
            errors++;
            $display("FAIL async_reset got A=%b B=%b v=%b o=%b e=%b c=%0d required all zero",
                     bus.palabraA, bus.palabraB, bus.palabra_valida, bus.ocupado,
                     bus.error_trama, bus.cuenta_tramas);
        end
        #2;
        rst_n = 1'b1;
        send_bit(1'b1, 1'b1);
        checks++;
        if (bus.ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_to_idle got o=%b required 0", bus.ocupado);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 255; i++) begin
            load_frame(3'b101, 3'b001);
            accept();
        end
        checks++;
        if (bus.cuenta_tramas !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255 got %0d required 255", bus.cuenta_tramas);
        end
        load_frame(3'b101, 3'b001);
        accept();
        checks++;
        if (bus.cuenta_tramas !== 8'd0) begin
            errors++;
            $display("FAIL wrap_to_zero got %0d required 0", bus.cuenta_tramas);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit exceeded");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_gaps();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
